// File: rtl/decoder_pkg.sv
// Shared encodings and width helper for the sequenced one-hot decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_PULSE  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_SCAN  = 2'b10
  } state_e;

  function automatic int unsigned out_w(input int unsigned in_w);
    return 32'd1 << in_w;
  endfunction

endpackage

// File: rtl/decoder_seq_n_onehot_dec.sv
// Combinational IN_W-to-2^IN_W one-hot decoder with enable; registered by the parent.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W = 4
) (
  input  logic                     en,
  input  logic [IN_W-1:0]          sel,
  output logic [out_w(IN_W)-1:0]   dec
);

  always_comb begin
    dec = '0;
    if (en) dec[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq_n.sv
// Registered one-hot decoder with DIRECT, PULSE (single dwell) and SCAN (full sweep) modes.
module decoder_seq_n
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W    = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [IN_W-1:0]         in,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic                    start,
  output logic [out_w(IN_W)-1:0]  out,
  output logic [IN_W-1:0]         index,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned OUT_W = out_w(IN_W);

  state_e             state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [IN_W-1:0]    idx_n;
  logic               en_n, busy_n, done_n;
  logic [OUT_W-1:0]   dec;

  // The decoder sees next-cycle index/enable so out, index and busy update together.
  onehot_dec #(.IN_W(IN_W)) u_dec (
    .en  (en_n),
    .sel (idx_n),
    .dec (dec)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dwell_n = dwell_q;
    idx_n   = '0;
    en_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          case (mode_e'(mode))
            MODE_DIRECT: begin
              idx_n = in;
              en_n  = 1'b1;
            end
            MODE_PULSE: begin
              if (start) begin
                state_n = ST_PULSE;
                cnt_n   = dwell;
                dwell_n = dwell;
                idx_n   = in;
                en_n    = 1'b1;
                busy_n  = 1'b1;
              end
            end
            MODE_SCAN: begin
              if (start) begin
                state_n = ST_SCAN;
                cnt_n   = dwell;
                dwell_n = dwell;
                en_n    = 1'b1;
                busy_n  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_PULSE, ST_SCAN: begin
        if (!enable) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt != '0) begin
          cnt_n  = cnt - 1'b1;
          idx_n  = index;
          en_n   = 1'b1;
          busy_n = 1'b1;
        end else if (state == ST_SCAN && index != '1) begin
          cnt_n  = dwell_q;
          idx_n  = index + 1'b1;
          en_n   = 1'b1;
          busy_n = 1'b1;
        end else begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      dwell_q <= '0;
      out     <= '0;
      index   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      dwell_q <= dwell_n;
      out     <= dec;
      index   <= idx_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_decoder_seq_n.sv
// Scoreboard bench for decoder_seq_n at IN_W=4, 2 and 6.
module tb_decoder_seq_n;
  import decoder_pkg::*;

  typedef struct packed {
    logic [63:0] out;
    logic [5:0]  idx;
    logic        busy;
    logic        done;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  obs_t sb[$];

  logic        a_enable = 1'b0, a_start = 1'b0;
  logic [1:0]  a_mode = 2'b00;
  logic [3:0]  a_in = '0;
  logic [7:0]  a_dwell = '0;
  logic [15:0] a_out;
  logic [3:0]  a_index;
  logic        a_busy, a_done;

  logic        b_enable = 1'b0, b_start = 1'b0;
  logic [1:0]  b_mode = 2'b00;
  logic [1:0]  b_in = '0;
  logic [7:0]  b_dwell = '0;
  logic [3:0]  b_out;
  logic [1:0]  b_index;
  logic        b_busy, b_done;

  logic        c_enable = 1'b0, c_start = 1'b0;
  logic [1:0]  c_mode = 2'b00;
  logic [5:0]  c_in = '0;
  logic [7:0]  c_dwell = '0;
  logic [63:0] c_out;
  logic [5:0]  c_index;
  logic        c_busy, c_done;

  decoder_seq_n #(.IN_W(4), .DWELL_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(a_enable), .mode(a_mode), .in(a_in),
    .dwell(a_dwell), .start(a_start), .out(a_out), .index(a_index),
    .busy(a_busy), .done(a_done));

  decoder_seq_n #(.IN_W(2), .DWELL_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .mode(b_mode), .in(b_in),
    .dwell(b_dwell), .start(b_start), .out(b_out), .index(b_index),
    .busy(b_busy), .done(b_done));

  decoder_seq_n #(.IN_W(6), .DWELL_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(c_enable), .mode(c_mode), .in(c_in),
    .dwell(c_dwell), .start(c_start), .out(c_out), .index(c_index),
    .busy(c_busy), .done(c_done));

  function automatic obs_t mk(input logic [63:0] o, input int i, input logic b, input logic d);
    logic [5:0] iv;
    iv = i[5:0];
    return {o, iv, b, d};
  endfunction

  function automatic obs_t obs_a();
    return {48'd0, a_out, 2'd0, a_index, a_busy, a_done};
  endfunction

  function automatic obs_t obs_b();
    return {60'd0, b_out, 4'd0, b_index, b_busy, b_done};
  endfunction

  task automatic test_reset();
    obs_t o;
    a_enable = 1'b1; a_mode = MODE_DIRECT; a_in = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    o = obs_a();
    tests_run++;
    if (o !== mk(64'd0, 0, 1'b0, 1'b0)) begin
      tests_failed++;
      $display("FAIL reset: got out=%h idx=%0d busy=%b done=%b, want all zero",
               o.out, o.idx, o.busy, o.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_direct();
    obs_t e, o;
    sb.push_back(mk(64'h0020, 5, 1'b0, 1'b0));
    sb.push_back(mk(64'h0000, 0, 1'b0, 1'b0));
    sb.push_back(mk(64'h0001, 0, 1'b0, 1'b0));
    sb.push_back(mk(64'h8000, 15, 1'b0, 1'b0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs_a();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL direct[%0d]: got out=%h idx=%0d busy=%b done=%b, want out=%h idx=%0d busy=%b done=%b",
                 k, o.out, o.idx, o.busy, o.done, e.out, e.idx, e.busy, e.done);
      end
      case (k)
        0: begin a_enable = 1'b0; a_in = 4'd15; end
        1: begin a_enable = 1'b1; a_in = 4'd0; a_start = 1'b1; end
        2: begin a_in = 4'd15; a_start = 1'b0; end
        default: ;
      endcase
    end
  endtask

  task automatic test_pulse();
    obs_t e, o;
    a_mode = MODE_PULSE; a_in = 4'd3; a_dwell = 8'd2; a_start = 1'b1;
    repeat (3) sb.push_back(mk(64'h0008, 3, 1'b1, 1'b0));
    sb.push_back(mk(64'd0, 0, 1'b0, 1'b1));
    sb.push_back(mk(64'd0, 0, 1'b0, 1'b0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs_a();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL pulse[%0d]: got out=%h idx=%0d busy=%b done=%b, want out=%h idx=%0d busy=%b done=%b",
                 k, o.out, o.idx, o.busy, o.done, e.out, e.idx, e.busy, e.done);
      end
      if (k < 2) begin
        a_in = 4'($urandom); a_dwell = 8'($urandom); a_mode = 2'($urandom);
      end else if (k == 2) begin
        a_start = 1'b0; a_mode = MODE_PULSE;
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    a_mode = MODE_PULSE; a_in = 4'd7; a_dwell = 8'd0; a_start = 1'b1;
    sb.push_back(mk(64'h0080, 7, 1'b1, 1'b0));
    sb.push_back(mk(64'd0, 0, 1'b0, 1'b1));
    sb.push_back(mk(64'h0080, 7, 1'b1, 1'b0));
    sb.push_back(mk(64'd0, 0, 1'b0, 1'b1));
    sb.push_back(mk(64'd0, 0, 1'b0, 1'b0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs_a();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got out=%h idx=%0d busy=%b done=%b, want out=%h idx=%0d busy=%b done=%b",
                 k, o.out, o.idx, o.busy, o.done, e.out, e.idx, e.busy, e.done);
      end
      if (k == 2) a_start = 1'b0;
    end
  endtask

  task automatic test_abort();
    obs_t e, o;
    a_mode = MODE_SCAN; a_dwell = 8'd1; a_start = 1'b1;
    for (int i = 0; i < 6; i++) repeat (2) sb.push_back(mk(64'd1 << i, i, 1'b1, 1'b0));
    sb.push_back(mk(64'h0040, 6, 1'b1, 1'b0));
    repeat (2) sb.push_back(mk(64'd0, 0, 1'b0, 1'b0));
    for (int i = 0; i < 16; i++) repeat (2) sb.push_back(mk(64'd1 << i, i, 1'b1, 1'b0));
    sb.push_back(mk(64'd0, 0, 1'b0, 1'b1));
    sb.push_back(mk(64'd0, 0, 1'b0, 1'b0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs_a();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL abort_scan[%0d]: got out=%h idx=%0d busy=%b done=%b, want out=%h idx=%0d busy=%b done=%b",
                 k, o.out, o.idx, o.busy, o.done, e.out, e.idx, e.busy, e.done);
      end
      case (k)
        12: begin a_enable = 1'b0; a_start = 1'b0; end
        14: begin a_enable = 1'b1; a_start = 1'b1; end
        15: a_start = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_rsvd();
    obs_t e, o;
    a_mode = MODE_RSVD; a_in = 4'd5; a_start = 1'b1;
    repeat (3) sb.push_back(mk(64'd0, 0, 1'b0, 1'b0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs_a();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL rsvd[%0d]: got out=%h idx=%0d busy=%b done=%b, want out=%h idx=%0d busy=%b done=%b",
                 k, o.out, o.idx, o.busy, o.done, e.out, e.idx, e.busy, e.done);
      end
    end
    a_start = 1'b0; a_mode = MODE_DIRECT;
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    a_mode = MODE_PULSE; a_in = 4'd9; a_dwell = 8'd10; a_start = 1'b1;
    repeat (2) sb.push_back(mk(64'h0200, 9, 1'b1, 1'b0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs_a();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL async_pre[%0d]: got out=%h idx=%0d busy=%b done=%b, want out=%h idx=%0d busy=%b done=%b",
                 k, o.out, o.idx, o.busy, o.done, e.out, e.idx, e.busy, e.done);
      end
      a_start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    o = obs_a();
    tests_run++;
    if (o !== mk(64'd0, 0, 1'b0, 1'b0)) begin
      tests_failed++;
      $display("FAIL async_reset: got out=%h idx=%0d busy=%b done=%b, want all zero",
               o.out, o.idx, o.busy, o.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(64'd0, 0, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs_a();
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL async_release: got out=%h idx=%0d busy=%b done=%b, want all zero",
               o.out, o.idx, o.busy, o.done);
    end
  endtask

  task automatic test_scan_small();
    obs_t e, o;
    for (int pass = 0; pass < 2; pass++) begin
      b_enable = 1'b1; b_mode = MODE_SCAN; b_start = 1'b1;
      b_dwell = (pass == 0) ? 8'd0 : 8'd3;
      for (int i = 0; i < 4; i++)
        repeat (int'(b_dwell) + 1) sb.push_back(mk(64'd1 << i, i, 1'b1, 1'b0));
      sb.push_back(mk(64'd0, 0, 1'b0, 1'b1));
      sb.push_back(mk(64'd0, 0, 1'b0, 1'b0));
      for (int k = 0; sb.size() > 0; k++) begin
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs_b();
        tests_run++;
        if (o !== e) begin
          tests_failed++;
          $display("FAIL scan4_d%0d[%0d]: got out=%h idx=%0d busy=%b done=%b, want out=%h idx=%0d busy=%b done=%b",
                   b_dwell, k, o.out, o.idx, o.busy, o.done, e.out, e.idx, e.busy, e.done);
        end
        b_start = 1'b0;
      end
    end
  endtask

  task automatic test_scan_large();
    int cycles = 0;
    int bad = 0;
    int exp_idx;
    c_enable = 1'b1; c_mode = MODE_SCAN; c_dwell = 8'd255; c_start = 1'b1;
    while (c_done !== 1'b1 && cycles < 16400) begin
      @(posedge clk); #1;
      c_start = 1'b0;
      if (c_done !== 1'b1) begin
        exp_idx = cycles >> 8;
        if (c_out !== (64'd1 << exp_idx) || c_index !== 6'(exp_idx) || c_busy !== 1'b1) bad++;
        cycles++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL scan64_steps: got %0d bad step cycles, want 0", bad);
    end
    tests_run++;
    if (cycles != 16384) begin
      tests_failed++;
      $display("FAIL scan64_len: got %0d busy cycles, want 16384", cycles);
    end
    tests_run++;
    if (c_done !== 1'b1 || c_busy !== 1'b0 || c_out !== 64'd0) begin
      tests_failed++;
      $display("FAIL scan64_done: got done=%b busy=%b out=%h, want done=1 busy=0 out=0",
               c_done, c_busy, c_out);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_direct();
    test_pulse();
    test_back_to_back();
    test_abort();
    test_rsvd();
    test_async_reset();
    test_scan_small();
    test_scan_large();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
